change_dispense_ctrl: RTL and testbench

Sequencer for the vending machine's coin-return path. It accepts a change amount over a valid/ready handshake and picks coins greedily, largest first, against per-hopper inventory. It drives one strobe per coin hopper (quarter, dime, nickel, penny) with programmable pulse and gap timing, and reports per-denomination counts plus a shortage flag when inventory cannot cover the amount. It sits between the purchase/credit logic and the physical hopper drivers.

---
 rtl/change_dispense_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: greedy largest-first coin selection against per-hopper
// inventory, one hopper strobe at a time with programmable pulse/gap timing.
module change_dispense_ctrl #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int INV_INIT     = 15
) (
    input  logic       clk,
    input  logic       reset,
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_valid must be held until that edge.
    input  logic       req_valid,
    input  logic [9:0] req_amount,
    output logic       req_ready,
    input  logic       refill,
    output logic       disp_q,
    output logic       disp_d,
    output logic       disp_n,
    output logic       disp_p,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] q_cnt,
    output logic [7:0] d_cnt,
    output logic [7:0] n_cnt,
    output logic [7:0] p_cnt,
    output logic [9:0] total,
    output logic [3:0] inv_empty,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Denomination index: 0 = quarter, 1 = dime, 2 = nickel, 3 = penny.
    function automatic logic [9:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_value = 10'd25;
            2'd1:    coin_value = 10'd10;
            2'd2:    coin_value = 10'd5;
            default: coin_value = 10'd1;
        endcase
    endfunction

    state_t        state, state_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [9:0]    amount, amount_nxt;
    logic [9:0]    total_nxt;
    logic          short_nxt;
    logic [7:0]    cnt [4];
    logic [7:0]    cnt_nxt [4];
    logic [7:0]    inv [4];
    logic [7:0]    inv_nxt [4];

    logic [9:0]    rem;
    logic [1:0]    pick;
    logic          pick_ok;

    assign req_ready = ~busy & ~refill;
    assign dbg_state = state;
    assign q_cnt     = cnt[0];
    assign d_cnt     = cnt[1];
    assign n_cnt     = cnt[2];
    assign p_cnt     = cnt[3];

    // Scan smallest to largest so the largest eligible coin wins.
    always_comb begin
        rem     = amount - total;
        pick    = 2'd0;
        pick_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (inv[i] != 8'd0 && coin_value(2'(i)) <= rem) begin
                pick    = 2'(i);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        tmr_nxt    = tmr;
        amount_nxt = amount;
        total_nxt  = total;
        short_nxt  = short;
        cnt_nxt    = cnt;
        inv_nxt    = inv;
        case (state)
            S_IDLE: begin
                if (refill) begin
                    for (int i = 0; i < 4; i++) inv_nxt[i] = 8'(INV_INIT);
                end else if (req_valid) begin
                    amount_nxt = req_amount;
                    total_nxt  = 10'd0;
                    short_nxt  = 1'b0;
                    for (int i = 0; i < 4; i++) cnt_nxt[i] = 8'd0;
                    state_nxt  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (amount[9]) begin
                    short_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else if (rem == 10'd0) begin
                    short_nxt = 1'b0;
                    state_nxt = S_DONE;
                end else if (pick_ok) begin
                    sel_nxt   = pick;
                    tmr_nxt   = '0;
                    state_nxt = S_PULSE;
                end else begin
                    short_nxt = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_PULSE: begin
                // Bookkeeping happens on the last strobe cycle of each coin.
                if (tmr == TW'(PULSE_CYCLES - 1)) begin
                    inv_nxt[sel] = (inv[sel] != 8'd0) ? inv[sel] - 8'd1 : 8'd0;
                    cnt_nxt[sel] = cnt[sel] + 8'd1;
                    total_nxt    = total + coin_value(sel);
                    tmr_nxt      = '0;
                    state_nxt    = S_GAP;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_GAP: begin
                if (tmr == TW'(GAP_CYCLES - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = S_SELECT;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes, busy, done and inv_empty are registered from next-state values
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            sel       <= 2'd0;
            tmr       <= '0;
            amount    <= 10'd0;
            total     <= 10'd0;
            short     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            disp_q    <= 1'b0;
            disp_d    <= 1'b0;
            disp_n    <= 1'b0;
            disp_p    <= 1'b0;
            inv_empty <= {4{(INV_INIT == 0)}};
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'd0;
                inv[i] <= 8'(INV_INIT);
            end
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            tmr       <= tmr_nxt;
            amount    <= amount_nxt;
            total     <= total_nxt;
            short     <= short_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            disp_q    <= (state_nxt == S_PULSE) && (sel_nxt == 2'd0);
            disp_d    <= (state_nxt == S_PULSE) && (sel_nxt == 2'd1);
            disp_n    <= (state_nxt == S_PULSE) && (sel_nxt == 2'd2);
            disp_p    <= (state_nxt == S_PULSE) && (sel_nxt == 2'd3);
            inv_empty <= {inv_nxt[0] == 8'd0, inv_nxt[1] == 8'd0,
                          inv_nxt[2] == 8'd0, inv_nxt[3] == 8'd0};
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
                inv[i] <= inv_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: two instances (full and tiny inventory) driven
// with directed and random requests, checked against a greedy coin model.
module tb_change_dispense_ctrl;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 1 + P + G;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid [2];
    logic       refill [2];
    logic [9:0] req_amount [2];
    logic       req_ready [2];
    logic       disp_q [2], disp_d [2], disp_n [2], disp_p [2];
    logic       busy [2], done [2], short_o [2];
    logic [7:0] q_cnt [2], d_cnt [2], n_cnt [2], p_cnt [2];
    logic [9:0] total [2];
    logic [3:0] inv_empty [2];
    logic [2:0] dbg_state [2];

    int vectors = 0;
    int errors  = 0;
    int inv_m [2][4];
    int inv_init [2] = '{15, 2};
    int coin_val [4] = '{25, 10, 5, 1};
    logic [1:0] exp_q [$];

    change_dispense_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_INIT(15)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_amount(req_amount[0]),
        .req_ready(req_ready[0]), .refill(refill[0]), .disp_q(disp_q[0]), .disp_d(disp_d[0]),
        .disp_n(disp_n[0]), .disp_p(disp_p[0]), .busy(busy[0]), .done(done[0]),
        .short(short_o[0]), .q_cnt(q_cnt[0]), .d_cnt(d_cnt[0]), .n_cnt(n_cnt[0]),
        .p_cnt(p_cnt[0]), .total(total[0]), .inv_empty(inv_empty[0]), .dbg_state(dbg_state[0])
    );

    change_dispense_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_INIT(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_amount(req_amount[1]),
        .req_ready(req_ready[1]), .refill(refill[1]), .disp_q(disp_q[1]), .disp_d(disp_d[1]),
        .disp_n(disp_n[1]), .disp_p(disp_p[1]), .busy(busy[1]), .done(done[1]),
        .short(short_o[1]), .q_cnt(q_cnt[1]), .d_cnt(d_cnt[1]), .n_cnt(n_cnt[1]),
        .p_cnt(p_cnt[1]), .total(total[1]), .inv_empty(inv_empty[1]), .dbg_state(dbg_state[1])
    );

    always #5 clk = ~clk;

    task automatic reload_model(input int w);
        for (int i = 0; i < 4; i++) inv_m[w][i] = inv_init[w];
    endtask

    // Issue one request on instance w and check every cycle until the first IDLE cycle
    // after DONE. Called and returns at a falling edge.
    task automatic run_req(input int w, input logic [9:0] amt, input bit with_refill,
                           input string name);
        int cnt_e [4];
        int rem, k, n, lat, waited, slot, coin;
        logic [9:0] total_e;
        logic       short_e;
        logic [3:0] empty_e;
        logic [6:0] exp_v, got_v;
        exp_q.delete();
        req_valid[w]  = 1'b1;
        req_amount[w] = amt;
        if (with_refill) begin
            refill[w] = 1'b1;
            #1;
            vectors++;
            if (req_ready[w] !== 1'b0) begin
                errors++;
                $display("FAIL %s refill_ready: got %b want 0", name, req_ready[w]);
            end
            @(negedge clk);
            refill[w] = 1'b0;
            reload_model(w);
        end
        rem = amt;
        for (int i = 0; i < 4; i++) begin
            cnt_e[i] = 0;
            if (!amt[9]) begin
                k = rem / coin_val[i];
                if (k > inv_m[w][i]) k = inv_m[w][i];
                cnt_e[i] = k;
                rem -= k * coin_val[i];
                inv_m[w][i] -= k;
                repeat (k) exp_q.push_back(2'(i));
            end
        end
        short_e = amt[9] || (rem != 0);
        total_e = amt[9] ? 10'd0 : 10'(amt - rem);
        empty_e = {inv_m[w][0] == 0, inv_m[w][1] == 0, inv_m[w][2] == 0, inv_m[w][3] == 0};
        n   = exp_q.size();
        lat = n * T + 2;
        #1;
        waited = 0;
        while (req_ready[w] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (req_ready[w] !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_timeout: req_ready got %b want 1", name, req_ready[w]);
            req_valid[w] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[w] = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            exp_v = 7'd0;
            if (c >= 2) begin
                slot = c - 2;
                if (slot / T < n && slot % T < P) begin
                    coin = exp_q[slot / T];
                    exp_v[6 - coin] = 1'b1;
                end
            end
            exp_v[2] = (c == lat);
            exp_v[1] = (c <= lat);
            exp_v[0] = (c == lat + 1);
            got_v = {disp_q[w], disp_d[w], disp_n[w], disp_p[w], done[w], busy[w], req_ready[w]};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s qdnp_done_busy_ready cycle %0d: got %b want %b",
                         name, c, got_v, exp_v);
            end
            if (c == lat) begin
                vectors++;
                if ({q_cnt[w], d_cnt[w], n_cnt[w], p_cnt[w]} !==
                    {8'(cnt_e[0]), 8'(cnt_e[1]), 8'(cnt_e[2]), 8'(cnt_e[3])}) begin
                    errors++;
                    $display("FAIL %s counts: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name,
                             q_cnt[w], d_cnt[w], n_cnt[w], p_cnt[w],
                             cnt_e[0], cnt_e[1], cnt_e[2], cnt_e[3]);
                end
                vectors++;
                if (total[w] !== total_e) begin
                    errors++;
                    $display("FAIL %s total: got %0d want %0d", name, total[w], total_e);
                end
                vectors++;
                if (short_o[w] !== short_e) begin
                    errors++;
                    $display("FAIL %s short: got %b want %b", name, short_o[w], short_e);
                end
                vectors++;
                if (inv_empty[w] !== empty_e) begin
                    errors++;
                    $display("FAIL %s inv_empty: got %b want %b", name, inv_empty[w], empty_e);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input int w, input string name);
        logic [7:0] got_v;
        vectors++;
        got_v = {req_ready[w], busy[w], done[w], short_o[w],
                 disp_q[w], disp_d[w], disp_n[w], disp_p[w]};
        if (got_v !== 8'b1000_0000) begin
            errors++;
            $display("FAIL %s ready_busy_done_short_qdnp: got %b want 10000000", name, got_v);
        end
        vectors++;
        if ({q_cnt[w], d_cnt[w], n_cnt[w], p_cnt[w], total[w]} !== 42'd0) begin
            errors++;
            $display("FAIL %s counts_total: got %0d/%0d/%0d/%0d/%0d want 0", name,
                     q_cnt[w], d_cnt[w], n_cnt[w], p_cnt[w], total[w]);
        end
        vectors++;
        if (inv_empty[w] !== 4'b0000) begin
            errors++;
            $display("FAIL %s inv_empty: got %b want 0000", name, inv_empty[w]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reload_model(0);
        reload_model(1);
        check_idle_outputs(0, "reset_dut0");
        check_idle_outputs(1, "reset_dut1");
    endtask

    task automatic test_greedy_41;
        run_req(0, 10'd41, 1'b0, "req41");
    endtask

    task automatic test_small_inventory;
        run_req(1, 10'd75, 1'b0, "inv2_req75");
        run_req(1, 10'd100, 1'b1, "inv2_req100_refill");
    endtask

    task automatic test_zero_invalid;
        run_req(0, 10'd0, 1'b0, "req0");
        run_req(0, 10'd600, 1'b0, "req600_invalid");
    endtask

    task automatic test_reset_mid;
        refill[0] = 1'b1;
        @(negedge clk);
        refill[0] = 1'b0;
        reload_model(0);
        req_valid[0]  = 1'b1;
        req_amount[0] = 10'd41;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (disp_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid first_pulse disp_q: got %b want 1", disp_q[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reload_model(0);
        reload_model(1);
        check_idle_outputs(0, "reset_mid_dut0");
        check_idle_outputs(1, "reset_mid_dut1");
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if ({done[0], busy[0], disp_q[0], disp_d[0], disp_n[0], disp_p[0]} !== 6'd0) begin
                errors++;
                $display("FAIL reset_mid quiet cycle %0d: done/busy/qdnp got %b%b%b%b%b%b want 0",
                         c, done[0], busy[0], disp_q[0], disp_d[0], disp_n[0], disp_p[0]);
            end
        end
        run_req(1, 10'd60, 1'b0, "after_reset_inv2_req60");
    endtask

    task automatic test_back_to_back;
        run_req(0, 10'd30, 1'b0, "b2b_a");
        run_req(0, 10'd7, 1'b0, "b2b_b");
        run_req(0, 10'd99, 1'b0, "b2b_c");
    endtask

    task automatic test_random;
        int w;
        logic [9:0] amt;
        for (int r = 0; r < 24; r++) begin
            w = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) amt = 10'($urandom_range(512, 1023));
            else amt = 10'($urandom_range(0, 120));
            run_req(w, amt, ($urandom_range(0, 4) == 0), $sformatf("rand%0d_dut%0d", r, w));
        end
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            req_valid[w]  = 1'b0;
            refill[w]     = 1'b0;
            req_amount[w] = 10'd0;
        end
        test_reset();
        test_greedy_41();
        test_small_inventory();
        test_zero_invalid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
